// File: rtl/mul_div_unit.sv
// Iterative multiply/divide engine (1 bit per cycle) feeding the HI/LO registers.
// Signed ops work on magnitudes; sign correction happens in a single FIXUP cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             write_hi,
  output logic             write_lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 dvd_neg_q, dvd_neg_d;
  logic                 dbz_q, dbz_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  assign a_mag = (op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag = (op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quot_fix = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = dvd_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    dvd_neg_d = dvd_neg_q;
    dbz_d     = dbz_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_div_d = op[1];
          dbz_d    = 1'b0;
          if (op[1] && (b == '0)) begin
            state_d = StDone;
            hi_d    = a;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d   = StCalc;
            cnt_d     = '0;
            neg_d     = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            dvd_neg_d = op[0] & op[1] & a[WIDTH-1];
            acc_d     = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            opnd_d    = op[1] ? b_mag : a_mag;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFixup;
      end
      StFixup: begin
        state_d = StDone;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      dvd_neg_q <= dvd_neg_d;
      dbz_q     <= dbz_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign write_hi    = done;
  assign write_lo    = done;
  assign div_by_zero = done & dbz_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule
